cxs_tx_link_ctrl: RTL and testbench
===================================

# cxs_tx_link_ctrl

Transmit-side CXS link-layer controller for the PCIe-host CXS bridge family. It owns the CXS TX activation handshake, the credit counter and the flit output register, with a parametrised credit depth and optional per-byte check-bit generation. It sits between the bridge's TX flit source (register-space / DMA path) and the CXS_*_TX pins. It adds credit return on deactivation and protocol-error detection, which the current bridge top does not provide.

## Interface
Parameters:
- CXS_DATA_FLIT_WIDTH, 256: flit width; one of 256, 512, 1024.
- CXS_CNTL_WIDTH, 14: control width; one of 14, 36, 44.
- CXS_DATACHECK, 0: 1 enables check-bit generation and checking.
- MAX_CREDITS, 15: maximum credits held; range 1..15.
- DEACT_HINT_EN, 1: 1 means CXS_DEACT_HINT_TX starts deactivation.

Ports (`CW = $clog2(MAX_CREDITS+1)`):
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- link_en  in  1  software request for link up.
- err_clr  in  1  pulse; clears prot_err and chk_err.
- s_flit_data  in  CXS_DATA_FLIT_WIDTH  flit from source.
- s_flit_cntl  in  CXS_CNTL_WIDTH  control for that flit.
- s_flit_valid  in  1  source valid.
- s_flit_ready  out  1  flit accepted when valid && ready.
- CXS_ACTIVE_REQ_TX  out  1; CXS_ACTIVE_ACK_TX  in  1; CXS_DEACT_HINT_TX  in  1.
- CXS_DATA_TX  out  CXS_DATA_FLIT_WIDTH; CXS_CNTL_TX  out  CXS_CNTL_WIDTH; CXS_VALID_TX  out  1.
- CXS_DATA_CHK_TX  out  CXS_DATA_FLIT_WIDTH/8; CXS_CNTL_CHK_TX, CXS_VALID_CHK_TX  out  1.
- CXS_CRDGNT_TX, CXS_CRDGNT_CHK_TX  in  1; CXS_CRDRTN_TX, CXS_CRDRTN_CHK_TX  out  1.
- credit_cnt  out  CW  credits currently held.
- link_state  out  2  STOP=0, ACTIVATE=1, RUN=2, DEACTIVATE=3.
- prot_err, chk_err  out  1  sticky error flags.

## Operation
- FSM states:
  - STOP (REQ=0): go to ACTIVATE when link_en=1.
  - ACTIVATE (REQ=1): go to RUN on ACK=1. A drop of link_en here is ignored until RUN.
  - RUN (REQ=1): go to DEACTIVATE when link_en=0, or when DEACT_HINT_EN && CXS_DEACT_HINT_TX.
  - DEACTIVATE (REQ=0): go to STOP on ACK=0.
- s_flit_ready = (state==RUN) && (credit_cnt!=0). It is a combinational function of registers only and never depends on s_flit_valid.
- Credits:
  - A grant is counted in ACTIVATE, RUN and DEACTIVATE.
  - Each accepted flit consumes one credit.
  - Each return issued in DEACTIVATE consumes one credit.
  - A grant and a consume in the same cycle leave the count unchanged.
- Credit return: in DEACTIVATE with credit_cnt!=0, CXS_CRDRTN_TX=1 in the next cycle and credit_cnt is decremented. Returns are issued one per cycle.
- prot_err is set, sticky until err_clr, on any of:
  - a grant in STOP;
  - a grant with credit_cnt==MAX_CREDITS (the grant is dropped);
  - ACK falling in DEACTIVATE while credit_cnt!=0 (credit_cnt is forced to 0);
  - ACK falling in RUN (FSM goes to STOP, credit_cnt forced to 0).
- Check bits (CXS_DATACHECK=1) use odd parity:
  - each CHK bit = ~^ of its byte (DATA), of the full field (CNTL) or of the signal (VALID, CRDRTN);
  - a CXS_CRDGNT_CHK_TX mismatch with ~CXS_CRDGNT_TX sets chk_err.
- With CXS_DATACHECK=0, all CHK outputs are 0 and chk_err stays 0.
- If err_clr and a new error occur in the same cycle, the set wins.

## Timing
- Reset values:
  - state=STOP and all CXS outputs 0 (including CHK outputs, even with CXS_DATACHECK=1);
  - credit_cnt=0, s_flit_ready=0, prot_err=0, chk_err=0.
- Every CXS output is registered.
- Flit latency: a flit accepted in cycle N appears with CXS_VALID_TX=1 in cycle N+1. CXS_DATA_TX and CXS_CNTL_TX hold their last value when VALID=0.
- Activation latency:
  - link_en rising → REQ=1 one cycle later;
  - ACK rising → RUN and s_flit_ready possible one cycle later.
- A grant in cycle N is visible in credit_cnt in cycle N+1.
- Deactivation mid-stream: ready drops in the cycle after the trigger. A flit already registered still drives VALID for its one cycle.
- rst asserted mid-operation immediately returns to reset values. Credits are lost and no CRDRTN is issued.

## Structure
- Shared include cxs_link_defines.vh holds:
  - the state encodings CXS_LS_STOP/ACTIVATE/RUN/DEACTIVATE;
  - the credit-width macro;
  - the odd-parity function.
- Sub-module cxs_chk_gen: parametrised-width per-byte odd-parity generator, reused for the DATA and CNTL check bits.
- Top level: the FSM, the credit counter and the output register stage.

## Test plan
- Activation: link_en=1, ACK returned after 3 cycles, 4 grants → state RUN and credit_cnt=4 by cycle 6; s_flit_ready=1.
- Back-to-back flits: 4 credits, 6 valid flits, no further grants → exactly 4 CXS_VALID_TX pulses in consecutive cycles, then ready=0 and credit_cnt=0.
- Simultaneous grant and send: credit_cnt=1, grant and send every cycle for 10 cycles → credit_cnt stays 1 and 10 flits are sent.
- Deactivation return: credit_cnt=5, link_en=0 → REQ=0 next cycle; 5 consecutive CRDRTN pulses; ACK falls → STOP with credit_cnt=0 and prot_err=0.
- Errors:
  - with MAX_CREDITS=2, a third grant → prot_err=1 and credit_cnt=2;
  - ACK dropped in DEACTIVATE with credit_cnt=3 → prot_err=1 and credit_cnt=0;
  - err_clr clears both flags.
- Datacheck (CXS_DATACHECK=1): flit byte 0x00 → CHK bit 1, byte 0x01 → CHK bit 0; CRDGNT=1 with CRDGNT_CHK=1 → chk_err=1.
- Reset mid-operation: rst asserted mid-burst → all outputs 0 in the same cycle.

Source files
------------

// File: rtl/cxs_tx_link_ctrl_pkg.sv
// Shared definitions for the CXS TX link controller: link-state encodings,
// credit-counter width and the odd-parity helper used for all check bits.
package cxs_tx_link_ctrl_pkg;

    typedef enum logic [1:0] {
        CXS_LS_STOP       = 2'd0,
        CXS_LS_ACTIVATE   = 2'd1,
        CXS_LS_RUN        = 2'd2,
        CXS_LS_DEACTIVATE = 2'd3
    } cxs_link_state_e;

    // Widest field ever passed to the parity helper; narrower fields are
    // zero-extended, which leaves their parity unchanged.
    localparam int CXS_PAR_MAX_W = 1024;

    function automatic int cxs_credit_width(input int max_credits);
        return $clog2(max_credits + 1);
    endfunction

    function automatic logic cxs_odd_parity(input logic [CXS_PAR_MAX_W-1:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/cxs_tx_link_ctrl_chk_gen.sv
// Parametrised odd-parity generator: one check bit per GRP_W-bit group.
// Used with GRP_W=8 for flit data and GRP_W=WIDTH for the control field.
module cxs_chk_gen
    import cxs_tx_link_ctrl_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int GRP_W = 8
) (
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH/GRP_W-1:0] o_chk
);

    localparam int NGRP = WIDTH / GRP_W;

    generate
        for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
            assign o_chk[gi] = cxs_odd_parity(CXS_PAR_MAX_W'(i_data[gi*GRP_W +: GRP_W]));
        end
    endgenerate

endmodule

// File: rtl/cxs_tx_link_ctrl.sv
// CXS transmit link-layer controller: activation handshake FSM, credit
// counter with return on deactivation, registered flit/check-bit outputs.
module cxs_tx_link_ctrl
    import cxs_tx_link_ctrl_pkg::*;
#(
    parameter int CXS_DATA_FLIT_WIDTH = 256,
    parameter int CXS_CNTL_WIDTH      = 14,
    parameter int CXS_DATACHECK       = 0,
    parameter int MAX_CREDITS         = 15,
    parameter int DEACT_HINT_EN       = 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     link_en,
    input  logic                                     err_clr,
    input  logic [CXS_DATA_FLIT_WIDTH-1:0]           s_flit_data,
    input  logic [CXS_CNTL_WIDTH-1:0]                s_flit_cntl,
    input  logic                                     s_flit_valid,
    output logic                                     s_flit_ready,
    output logic                                     CXS_ACTIVE_REQ_TX,
    input  logic                                     CXS_ACTIVE_ACK_TX,
    input  logic                                     CXS_DEACT_HINT_TX,
    output logic [CXS_DATA_FLIT_WIDTH-1:0]           CXS_DATA_TX,
    output logic [CXS_CNTL_WIDTH-1:0]                CXS_CNTL_TX,
    output logic                                     CXS_VALID_TX,
    output logic [CXS_DATA_FLIT_WIDTH/8-1:0]         CXS_DATA_CHK_TX,
    output logic                                     CXS_CNTL_CHK_TX,
    output logic                                     CXS_VALID_CHK_TX,
    input  logic                                     CXS_CRDGNT_TX,
    input  logic                                     CXS_CRDGNT_CHK_TX,
    output logic                                     CXS_CRDRTN_TX,
    output logic                                     CXS_CRDRTN_CHK_TX,
    output logic [cxs_credit_width(MAX_CREDITS)-1:0] credit_cnt,
    output logic [1:0]                               link_state,
    output logic                                     prot_err,
    output logic                                     chk_err
);

    localparam int            CW      = cxs_credit_width(MAX_CREDITS);
    localparam int            DCW     = CXS_DATA_FLIT_WIDTH / 8;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_CREDITS);
    localparam logic          CHK_ON  = (CXS_DATACHECK != 0);
    localparam logic          HINT_ON = (DEACT_HINT_EN != 0);

    cxs_link_state_e r_state;
    cxs_link_state_e w_state_next;
    logic            w_ack_fault;

    logic [CW-1:0]   r_credit_cnt;
    logic [CW-1:0]   w_credit_next;

    logic                           r_req;
    logic                           r_valid;
    logic [CXS_DATA_FLIT_WIDTH-1:0] r_data;
    logic [CXS_CNTL_WIDTH-1:0]      r_cntl;
    logic [DCW-1:0]                 r_data_chk;
    logic                           r_cntl_chk;
    logic                           r_valid_chk;
    logic                           r_rtn;
    logic                           r_rtn_chk;
    logic                           r_prot_err;
    logic                           r_chk_err;

    logic           w_req_next;
    logic           w_run;
    logic           w_deact;
    logic           w_accept;
    logic           w_rtn;
    logic           w_consume;
    logic           w_grant_ok;
    logic           w_grant_err;
    logic           w_prot_set;
    logic           w_chk_set;
    logic [DCW-1:0] w_data_chk_raw;
    logic [0:0]     w_cntl_chk_raw;
    logic [DCW-1:0] w_data_chk;
    logic           w_cntl_chk;
    logic           w_valid_chk;
    logic           w_rtn_chk;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CXS_LS_STOP;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    // ACK dropping while REQ is still high (RUN), or while credits are still
    // held (DEACTIVATE), is a protocol fault that discards all credits.
    always_comb begin
        w_state_next = r_state;
        w_ack_fault  = 1'b0;
        case (r_state)
            CXS_LS_STOP: begin
                if (link_en) w_state_next = CXS_LS_ACTIVATE;
            end
            CXS_LS_ACTIVATE: begin
                if (CXS_ACTIVE_ACK_TX) w_state_next = CXS_LS_RUN;
            end
            CXS_LS_RUN: begin
                if (!CXS_ACTIVE_ACK_TX) begin
                    w_state_next = CXS_LS_STOP;
                    w_ack_fault  = 1'b1;
                end else if (!link_en || (HINT_ON && CXS_DEACT_HINT_TX)) begin
                    w_state_next = CXS_LS_DEACTIVATE;
                end
            end
            CXS_LS_DEACTIVATE: begin
                if (!CXS_ACTIVE_ACK_TX) begin
                    w_state_next = CXS_LS_STOP;
                    w_ack_fault  = (r_credit_cnt != '0);
                end
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_run        = (r_state == CXS_LS_RUN);
        w_deact      = (r_state == CXS_LS_DEACTIVATE);
        w_req_next   = (w_state_next == CXS_LS_ACTIVATE) || (w_state_next == CXS_LS_RUN);
        s_flit_ready = w_run && (r_credit_cnt != '0);
        link_state   = r_state;
    end

    // ---------------- Credit accounting ----------------
    // A return needs ACK still high; on an ACK-fault cycle credits are
    // discarded instead of returned.
    assign w_accept    = s_flit_valid && s_flit_ready;
    assign w_rtn       = w_deact && (r_credit_cnt != '0) && CXS_ACTIVE_ACK_TX;
    assign w_consume   = w_accept || w_rtn;
    assign w_grant_err = CXS_CRDGNT_TX && ((r_state == CXS_LS_STOP) || (r_credit_cnt == MAX_CNT));
    assign w_grant_ok  = CXS_CRDGNT_TX && !w_grant_err;
    assign w_prot_set  = w_grant_err || w_ack_fault;
    assign w_chk_set   = CHK_ON &&
                         (CXS_CRDGNT_CHK_TX != cxs_odd_parity(CXS_PAR_MAX_W'(CXS_CRDGNT_TX)));

    always_comb begin
        w_credit_next = r_credit_cnt;
        if (w_ack_fault) begin
            w_credit_next = '0;
        end else if (w_grant_ok && !w_consume) begin
            w_credit_next = r_credit_cnt + 1'b1;
        end else if (!w_grant_ok && w_consume) begin
            w_credit_next = r_credit_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit_cnt <= '0;
        end else begin
            r_credit_cnt <= w_credit_next;
        end
    end

    // A new error in the same cycle as err_clr takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prot_err <= 1'b0;
            r_chk_err  <= 1'b0;
        end else begin
            if (w_prot_set) begin
                r_prot_err <= 1'b1;
            end else if (err_clr) begin
                r_prot_err <= 1'b0;
            end
            if (w_chk_set) begin
                r_chk_err <= 1'b1;
            end else if (err_clr) begin
                r_chk_err <= 1'b0;
            end
        end
    end

    // ---------------- Check-bit generation ----------------
    cxs_chk_gen #(
        .WIDTH (CXS_DATA_FLIT_WIDTH),
        .GRP_W (8)
    ) u_data_chk (
        .i_data (s_flit_data),
        .o_chk  (w_data_chk_raw)
    );

    cxs_chk_gen #(
        .WIDTH (CXS_CNTL_WIDTH),
        .GRP_W (CXS_CNTL_WIDTH)
    ) u_cntl_chk (
        .i_data (s_flit_cntl),
        .o_chk  (w_cntl_chk_raw)
    );

    assign w_data_chk  = CHK_ON ? w_data_chk_raw : '0;
    assign w_cntl_chk  = CHK_ON && w_cntl_chk_raw[0];
    assign w_valid_chk = CHK_ON && cxs_odd_parity(CXS_PAR_MAX_W'(w_accept));
    assign w_rtn_chk   = CHK_ON && cxs_odd_parity(CXS_PAR_MAX_W'(w_rtn));

    // ---------------- Output register stage ----------------
    // Data, control and their check bits only load on an accepted flit so
    // they hold their last value while VALID is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req       <= 1'b0;
            r_valid     <= 1'b0;
            r_valid_chk <= 1'b0;
            r_rtn       <= 1'b0;
            r_rtn_chk   <= 1'b0;
            r_data      <= '0;
            r_cntl      <= '0;
            r_data_chk  <= '0;
            r_cntl_chk  <= 1'b0;
        end else begin
            r_req       <= w_req_next;
            r_valid     <= w_accept;
            r_valid_chk <= w_valid_chk;
            r_rtn       <= w_rtn;
            r_rtn_chk   <= w_rtn_chk;
            if (w_accept) begin
                r_data     <= s_flit_data;
                r_cntl     <= s_flit_cntl;
                r_data_chk <= w_data_chk;
                r_cntl_chk <= w_cntl_chk;
            end
        end
    end

    assign CXS_ACTIVE_REQ_TX = r_req;
    assign CXS_VALID_TX      = r_valid;
    assign CXS_DATA_TX       = r_data;
    assign CXS_CNTL_TX       = r_cntl;
    assign CXS_DATA_CHK_TX   = r_data_chk;
    assign CXS_CNTL_CHK_TX   = r_cntl_chk;
    assign CXS_VALID_CHK_TX  = r_valid_chk;
    assign CXS_CRDRTN_TX     = r_rtn;
    assign CXS_CRDRTN_CHK_TX = r_rtn_chk;
    assign credit_cnt        = r_credit_cnt;
    assign prot_err          = r_prot_err;
    assign chk_err           = r_chk_err;

endmodule

// File: tb/tb_cxs_tx_link_ctrl.sv
// Directed + randomized bench for cxs_tx_link_ctrl, checked cycle by cycle
// against a behavioural model of the link rules.
module tb_cxs_tx_link_ctrl;

    localparam int DW   = 256;
    localparam int CNW  = 14;
    localparam int MAXC = 15;
    localparam int CW   = 4;
    localparam int DCW  = DW / 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           link_en = 1'b0;
    logic           err_clr = 1'b0;
    logic [DW-1:0]  s_data = '0;
    logic [CNW-1:0] s_cntl = '0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic           ack = 1'b0;
    logic           deact_hint = 1'b0;
    logic           gnt = 1'b0;
    logic           gnt_bad = 1'b0;
    logic           gnt_chk = 1'b1;

    logic           req;
    logic [DW-1:0]  tx_data;
    logic [CNW-1:0] tx_cntl;
    logic           tx_valid;
    logic [DCW-1:0] tx_dchk;
    logic           tx_cchk;
    logic           tx_vchk;
    logic           rtn;
    logic           rtn_chk;
    logic [CW-1:0]  credit_cnt;
    logic [1:0]     link_state;
    logic           prot_err;
    logic           chk_err;

    always #5 clk = ~clk;

    cxs_tx_link_ctrl #(
        .CXS_DATA_FLIT_WIDTH (DW),
        .CXS_CNTL_WIDTH      (CNW),
        .CXS_DATACHECK       (1),
        .MAX_CREDITS         (MAXC),
        .DEACT_HINT_EN       (1)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .link_en           (link_en),
        .err_clr           (err_clr),
        .s_flit_data       (s_data),
        .s_flit_cntl       (s_cntl),
        .s_flit_valid      (s_valid),
        .s_flit_ready      (s_ready),
        .CXS_ACTIVE_REQ_TX (req),
        .CXS_ACTIVE_ACK_TX (ack),
        .CXS_DEACT_HINT_TX (deact_hint),
        .CXS_DATA_TX       (tx_data),
        .CXS_CNTL_TX       (tx_cntl),
        .CXS_VALID_TX      (tx_valid),
        .CXS_DATA_CHK_TX   (tx_dchk),
        .CXS_CNTL_CHK_TX   (tx_cchk),
        .CXS_VALID_CHK_TX  (tx_vchk),
        .CXS_CRDGNT_TX     (gnt),
        .CXS_CRDGNT_CHK_TX (gnt_chk),
        .CXS_CRDRTN_TX     (rtn),
        .CXS_CRDRTN_CHK_TX (rtn_chk),
        .credit_cnt        (credit_cnt),
        .link_state        (link_state),
        .prot_err          (prot_err),
        .chk_err           (chk_err)
    );

    // Reference model state (0=STOP 1=ACTIVATE 2=RUN 3=DEACTIVATE)
    int             m_state;
    int             m_cnt;
    bit             m_req, m_valid, m_rtn, m_prot, m_cerr, m_vchk, m_rchk, m_cchk;
    logic [DW-1:0]  m_data;
    logic [CNW-1:0] m_cntl;
    logic [DCW-1:0] m_dchk;

    int vectors     = 0;
    int miscompares = 0;
    int valid_pulses;
    int rtn_pulses;
    int flit_no     = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0;
        m_req = 0; m_valid = 0; m_rtn = 0; m_prot = 0; m_cerr = 0;
        m_vchk = 0; m_rchk = 0; m_cchk = 0;
        m_data = '0; m_cntl = '0; m_dchk = '0;
    endtask

    task automatic check_all();
        chk("link_state", DW'(link_state), DW'(m_state));
        chk("req",        DW'(req),        DW'(m_req));
        chk("credit_cnt", DW'(credit_cnt), DW'(m_cnt));
        chk("ready",      DW'(s_ready),    DW'(m_state == 2 && m_cnt != 0));
        chk("valid",      DW'(tx_valid),   DW'(m_valid));
        chk("data",       tx_data,         m_data);
        chk("cntl",       DW'(tx_cntl),    DW'(m_cntl));
        chk("data_chk",   DW'(tx_dchk),    DW'(m_dchk));
        chk("cntl_chk",   DW'(tx_cchk),    DW'(m_cchk));
        chk("valid_chk",  DW'(tx_vchk),    DW'(m_vchk));
        chk("crdrtn",     DW'(rtn),        DW'(m_rtn));
        chk("crdrtn_chk", DW'(rtn_chk),    DW'(m_rchk));
        chk("prot_err",   DW'(prot_err),   DW'(m_prot));
        chk("chk_err",    DW'(chk_err),    DW'(m_cerr));
    endtask

    // Applies the current inputs for one clock and checks the result.
    task automatic step();
        int             ns, nc;
        bit             rdy, acc, inc, rtn_now, force0, perr;
        logic [DCW-1:0] nd;

        gnt_chk = ~gnt ^ gnt_bad;
        rdy     = (m_state == 2) && (m_cnt != 0);
        acc     = s_valid && rdy;
        inc     = 0; perr = 0; force0 = 0;
        if (gnt) begin
            if (m_state == 0 || m_cnt == MAXC) perr = 1;
            else inc = 1;
        end
        rtn_now = (m_state == 3) && (m_cnt != 0) && ack;
        ns = m_state;
        if (m_state == 0 && link_en) ns = 1;
        else if (m_state == 1 && ack) ns = 2;
        else if (m_state == 2 && !ack) begin ns = 0; force0 = 1; perr = 1; end
        else if (m_state == 2 && (!link_en || deact_hint)) ns = 3;
        else if (m_state == 3 && !ack) begin
            ns = 0;
            if (m_cnt != 0) begin force0 = 1; perr = 1; end
        end
        nc = force0 ? 0 : m_cnt + int'(inc) - int'(acc) - int'(rtn_now);
        for (int b = 0; b < DCW; b++) nd[b] = ~^s_data[b*8 +: 8];

        @(posedge clk);
        #1;
        if (acc) begin
            m_data = s_data; m_cntl = s_cntl; m_dchk = nd; m_cchk = ~^s_cntl;
        end
        m_cerr  = (gnt_chk != ~gnt) ? 1'b1 : (err_clr ? 1'b0 : m_cerr);
        m_prot  = perr ? 1'b1 : (err_clr ? 1'b0 : m_prot);
        m_state = ns;
        m_cnt   = nc;
        m_req   = (ns == 1 || ns == 2);
        m_valid = acc;
        m_vchk  = ~acc;
        m_rtn   = rtn_now;
        m_rchk  = ~rtn_now;
        check_all();
        if (tx_valid) valid_pulses++;
        if (rtn) rtn_pulses++;
        if (acc) begin
            flit_no++;
            $display("flit %0d cntl=%h data[31:0]=%h credits=%0d", flit_no, s_cntl, s_data[31:0], nc);
        end
    endtask

    task automatic new_flit();
        s_data = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
        s_cntl = CNW'($urandom());
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Activation: ACK three cycles after REQ, four grants
        link_en = 1'b1;
        step();
        chk("act_req_up", DW'(req), DW'(1));
        gnt = 1'b1;
        step(); step();
        ack = 1'b1;
        step(); step();
        gnt = 1'b0;
        chk("act_run",   DW'(link_state), DW'(2));
        chk("act_cnt4",  DW'(credit_cnt), DW'(4));
        chk("act_ready", DW'(s_ready),    DW'(1));

        // Back-to-back: 6 flits offered, 4 credits
        valid_pulses = 0;
        s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin new_flit(); step(); end
        s_valid = 1'b0;
        step();
        chk("b2b_pulses", DW'(valid_pulses), DW'(4));
        chk("b2b_cnt0",   DW'(credit_cnt),   DW'(0));
        chk("b2b_ready0", DW'(s_ready),      DW'(0));

        // Simultaneous grant and send with one credit
        gnt = 1'b1;
        step();
        valid_pulses = 0;
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin new_flit(); step(); end
        s_valid = 1'b0;
        gnt = 1'b0;
        chk("sim_pulses", DW'(valid_pulses), DW'(10));
        chk("sim_cnt1",   DW'(credit_cnt),   DW'(1));

        // Datacheck: byte 0x00 -> 1, byte 0x01 -> 0
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        s_valid = 1'b1;
        s_data = '0;
        step();
        chk("dchk_byte00", DW'(tx_dchk[0]), DW'(1));
        s_data = DW'(1);
        step();
        chk("dchk_byte01", DW'(tx_dchk[0]), DW'(0));
        s_valid = 1'b0;

        // Bad grant check bit
        gnt = 1'b1; gnt_bad = 1'b1;
        step();
        gnt_bad = 1'b0;
        chk("chk_err_set", DW'(chk_err), DW'(1));
        repeat (4) step();
        gnt = 1'b0;

        // Deactivation with 5 credits returned
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        link_en = 1'b0;
        step();
        chk("deact_req0", DW'(req), DW'(0));
        rtn_pulses = 0;
        repeat (6) step();
        chk("deact_rtn5", DW'(rtn_pulses), DW'(5));
        ack = 1'b0;
        step();
        chk("deact_stop",  DW'(link_state), DW'(0));
        chk("deact_cnt0",  DW'(credit_cnt), DW'(0));
        chk("deact_prot0", DW'(prot_err),   DW'(0));

        // Overflow grant
        link_en = 1'b1;
        step();
        ack = 1'b1;
        step();
        gnt = 1'b1;
        repeat (MAXC + 1) step();
        gnt = 1'b0;
        chk("ovf_prot",  DW'(prot_err),   DW'(1));
        chk("ovf_cnt",   DW'(credit_cnt), DW'(MAXC));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("ovf_clr",   DW'(prot_err),   DW'(0));

        // ACK dropped in DEACTIVATE with 3 credits held
        s_valid = 1'b1;
        for (int i = 0; i < MAXC - 3; i++) begin new_flit(); step(); end
        s_valid = 1'b0;
        link_en = 1'b0;
        step();
        chk("ackdrop_pre_cnt", DW'(credit_cnt), DW'(3));
        ack = 1'b0;
        step();
        chk("ackdrop_prot",  DW'(prot_err),   DW'(1));
        chk("ackdrop_cnt0",  DW'(credit_cnt), DW'(0));
        chk("ackdrop_stop",  DW'(link_state), DW'(0));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_prot", DW'(prot_err), DW'(0));
        chk("clr_chk",  DW'(chk_err),  DW'(0));

        // Reset mid-burst
        link_en = 1'b1;
        step();
        ack = 1'b1;
        step();
        gnt = 1'b1;
        repeat (3) step();
        s_valid = 1'b1;
        new_flit(); step();
        new_flit(); step();
        #1;
        rst = 1'b1;
        #1;
        chk("rst_valid",  DW'(tx_valid),   DW'(0));
        chk("rst_req",    DW'(req),        DW'(0));
        chk("rst_cnt",    DW'(credit_cnt), DW'(0));
        chk("rst_ready",  DW'(s_ready),    DW'(0));
        chk("rst_state",  DW'(link_state), DW'(0));
        chk("rst_data",   tx_data,         DW'(0));
        chk("rst_vchk",   DW'(tx_vchk),    DW'(0));
        chk("rst_rtnchk", DW'(rtn_chk),    DW'(0));
        model_reset();
        gnt = 1'b0; s_valid = 1'b0; link_en = 1'b0; ack = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) link_en = ~link_en;
            if (ack != m_req && $urandom_range(0, 2) == 0) ack = m_req;
            else if (ack && $urandom_range(0, 299) == 0) ack = 1'b0;
            deact_hint = ($urandom_range(0, 79) == 0);
            if ((m_state == 1 || m_state == 2) && m_cnt < MAXC)
                gnt = ($urandom_range(0, 2) == 0);
            else
                gnt = ($urandom_range(0, 59) == 0);
            gnt_bad = ($urandom_range(0, 99) == 0);
            err_clr = ($urandom_range(0, 29) == 0);
            s_valid = ($urandom_range(0, 1) == 1);
            new_flit();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
